// File: rtl/seven_seg_pkg.sv
// Purpose: shared types, hex-to-segment table and decode helper for the 7-segment scan path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents:
//   seg_pattern_t  - active-high segment vector {g,f,e,d,c,b,a}
//   hex_nibble_t   - one hex digit value
//   scan_state_t   - per-slot scan phase (BLANK / DRIVE)
//   HEX_TO_SEG     - 16-entry decode table, active-high
//   hex_to_seg()   - table lookup used by the scan controller
package seven_seg_pkg;

  typedef logic [6:0] seg_pattern_t;
  typedef logic [3:0] hex_nibble_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Standard hex glyphs 0-9, A, b, C, d, E, F (lower-case b and d keep them
  // distinguishable from 8 and 0).
  localparam seg_pattern_t HEX_TO_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_pattern_t hex_to_seg(input hex_nibble_t value);
    return HEX_TO_SEG[value];
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Purpose: slot prescaler; counts 0..DIV-1 and flags slot end and the blank window.
// Latency: all outputs are combinational decodes of the registered count.
// Backpressure: none; free-running.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset (count returns to 0)
//   tick          - high on the last cycle of a slot (count == DIV-1)
//   blank_active  - high while count < BLANK_CYCLES
//   blank_last    - high on the final blank cycle (count == BLANK_CYCLES-1)
//   slot_start    - high on the first cycle of a slot (count == 0)
module seg_tick_gen #(
  parameter int unsigned DIV          = 27_000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic blank_active,
  output logic blank_last,
  output logic slot_start
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  // A slot needs at least one blank-exit cycle and one drive cycle after the
  // blank window, otherwise the FSM never reaches DRIVE.
  if (DIV < BLANK_CYCLES + 2) begin : g_div_too_small
    $fatal(1, "seg_tick_gen: DIV must be at least BLANK_CYCLES+2");
  end

  logic [CW-1:0] cnt;

  assign tick         = (cnt == CW'(DIV - 1));
  assign slot_start   = (cnt == '0);
  assign blank_active = (32'(cnt) < BLANK_CYCLES);

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_last = 1'b0;
  end else begin : g_blank
    assign blank_last = (32'(cnt) == BLANK_CYCLES - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Purpose: double-buffered, time-multiplexed scan driver for multi-digit 7-segment displays.
// Latency: pins are registered, 1 cycle behind scan state; a loaded frame shows from the next frame.
// Backpressure: load_ready drops while a frame waits in the pending buffer; it frees at the frame boundary.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_valid   - frame data valid; load_ready - pending buffer empty
//   digit_data   - 4 bits per digit, digit i at [4i+3:4i]
//   dp_data      - decimal point per digit; digit_en - 1 = digit shown, 0 = blanked
//   digit_sel    - one-hot digit drive (polarity from DIG_ACTIVE_LOW)
//   seg, seg_dp  - segments {g..a} and decimal point (polarity from SEG_ACTIVE_LOW)
//   frame_start  - one-cycle pulse on the first output cycle of the digit-0 slot
module digit_scan_mux #(
  parameter int unsigned CLK_FREQ_HZ    = 27_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          DIG_ACTIVE_LOW = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic                    frame_start
);

  import seven_seg_pkg::*;

  localparam int unsigned DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int unsigned IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  // XOR masks: an all-zero active-high vector XORed with these gives the
  // "off" level on the pins for either polarity.
  localparam logic [NUM_DIGITS-1:0] SEL_POL  = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL  = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_POL   = SEG_ACTIVE_LOW;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $fatal(1, "digit_scan_mux: NUM_DIGITS must be in 1..8");
  end

  // ---------------------------------------------------------------------------
  // Slot timing
  // ---------------------------------------------------------------------------
  logic tick;
  logic blank_active;
  logic blank_last;
  logic slot_start;

  seg_tick_gen #(
    .DIV          (DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .blank_active (blank_active),
    .blank_last   (blank_last),
    .slot_start   (slot_start)
  );

  // ---------------------------------------------------------------------------
  // Digit index; the last digit's tick is the frame boundary. With a single
  // digit the index never moves and every tick is a boundary.
  // ---------------------------------------------------------------------------
  logic [IW-1:0] idx;
  logic          last_digit;
  logic          frame_boundary;

  assign last_digit     = (idx == LAST_IDX);
  assign frame_boundary = tick && last_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= last_digit ? '0 : idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending (load side) and shadow (display side) frame buffers.
  // Commit needs pend_full=1 and acceptance needs pend_full=0, so both can
  // never fire in the same cycle: a load landing on the boundary cycle waits
  // for the following boundary.
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_en;
  logic                    pend_full;
  logic [4*NUM_DIGITS-1:0] shd_data;
  logic [NUM_DIGITS-1:0]   shd_dp;
  logic [NUM_DIGITS-1:0]   shd_en;
  logic                    load_fire;

  assign load_ready = !pend_full;
  assign load_fire  = load_valid && !pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      pend_full <= 1'b0;
      shd_data  <= '0;
      shd_dp    <= '0;
      shd_en    <= '0;
    end else begin
      if (frame_boundary && pend_full) begin
        shd_data  <= pend_data;
        shd_dp    <= pend_dp;
        shd_en    <= pend_en;
        pend_full <= 1'b0;
      end
      if (load_fire) begin
        pend_data <= digit_data;
        pend_dp   <= dp_data;
        pend_en   <= digit_en;
        pend_full <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot FSM: state register / next-state / output decode
  // ---------------------------------------------------------------------------
  scan_state_t state;
  scan_state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // !blank_active only matters with BLANK_CYCLES=0, where there is no
      // last blank cycle to leave on.
      BLANK:   if (blank_last || !blank_active) state_nxt = DRIVE;
      DRIVE:   if (tick && (BLANK_CYCLES != 0)) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  logic [NUM_DIGITS-1:0] sel_nxt;
  seg_pattern_t          pat_nxt;
  logic                  dp_nxt;

  // Active-high view of the pins; a masked digit keeps its slot but stays dark.
  always_comb begin
    sel_nxt = '0;
    pat_nxt = '0;
    dp_nxt  = 1'b0;
    if ((state == DRIVE) && shd_en[idx]) begin
      sel_nxt[idx] = 1'b1;
      pat_nxt      = hex_to_seg(shd_data[{idx, 2'b00} +: 4]);
      dp_nxt       = shd_dp[idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Registered pins, polarity applied after decode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel   <= SEL_POL;
      seg         <= SEG_POL;
      seg_dp      <= DP_POL;
      frame_start <= 1'b0;
    end else begin
      digit_sel   <= sel_nxt ^ SEL_POL;
      seg         <= pat_nxt ^ SEG_POL;
      seg_dp      <= dp_nxt ^ DP_POL;
      frame_start <= slot_start && (idx == '0);
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
// Purpose: directed self-checking bench for digit_scan_mux (DIV=10, 4 digits, 2 blank cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_digit_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] digit_data = '0;
  logic [3:0]  dp_data = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  digit_sel;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  // Position within the 40-cycle frame of the outputs currently on the pins.
  int pos = 0;

  digit_scan_mux #(
    .CLK_FREQ_HZ    (1000),
    .SCAN_HZ        (100),
    .NUM_DIGITS     (4),
    .BLANK_CYCLES   (2),
    .DIG_ACTIVE_LOW (1'b0),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digit_data  (digit_data),
    .dp_data     (dp_data),
    .digit_en    (digit_en),
    .digit_sel   (digit_sel),
    .seg         (seg),
    .seg_dp      (seg_dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 40;
  endtask

  task automatic goto_pos(input int p);
    while (pos != p) step();
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    load_valid = 1'b1;
    digit_data = d;
    dp_data    = dp;
    digit_en   = en;
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected {digit_sel, seg, seg_dp, frame_start} at frame position p:
  // slot = p/10, first two cycles of each slot dark, active-low segments.
  function automatic logic [12:0] exp_pins(input int p, input logic [15:0] d,
                                           input logic [3:0] dp, input logic [3:0] en);
    int          slot = p / 10;
    int          off  = p % 10;
    logic [3:0]  sel  = 4'b0000;
    logic [6:0]  s    = 7'h7F;
    logic        sdp  = 1'b1;
    if (off >= 2 && en[slot]) begin
      sel[slot] = 1'b1;
      s   = ~hex7(d[slot*4 +: 4]);
      sdp = ~dp[slot];
    end
    return {sel, s, sdp, (p == 0)};
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({digit_sel, seg, seg_dp, frame_start, load_ready} !== {4'b0000, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", {digit_sel, seg, seg_dp, frame_start, load_ready},
               {4'b0000, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    rst_n = 1'b1;
    pos   = 39;
    for (int i = 0; i < 80; i++) begin
      step();
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start, load_ready} !== {4'b0000, 7'h7F, 1'b1, (pos == 0), 1'b1}) begin
        errors++;
        $display("FAIL reset_idle pos=%0d got=%h exp=%h", pos,
                 {digit_sel, seg, seg_dp, frame_start, load_ready}, {4'b0000, 7'h7F, 1'b1, (pos == 0), 1'b1});
      end
    end
  endtask

  task automatic test_load_display();
    logic [12:0] e;
    goto_pos(5);
    drive_load(16'h4321, 4'b0001, 4'b1111);
    step();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_fall got=%b exp=0", load_ready);
    end
    goto_pos(38);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_ready_hold got=%b exp=0", load_ready);
    end
    step();
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_rise got=%b exp=1", load_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      e = exp_pins(pos, 16'h4321, 4'b0001, 4'b1111);
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start} !== e) begin
        errors++;
        $display("FAIL load_frame pos=%0d got=%h exp=%h", pos, {digit_sel, seg, seg_dp, frame_start}, e);
      end
    end
    // Spot values for digit 0 and digit 3 computed by hand.
    checks++;
    if (exp_pins(2, 16'h4321, 4'b0001, 4'b1111) !== {4'b0001, 7'h79, 1'b0, 1'b0} ||
        exp_pins(35, 16'h4321, 4'b0001, 4'b1111) !== {4'b1000, 7'h19, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_model got=%h exp=%h", exp_pins(2, 16'h4321, 4'b0001, 4'b1111),
               {4'b0001, 7'h79, 1'b0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    goto_pos(10);
    drive_load(16'hABCD, 4'b1010, 4'b1111);
    step();
    digit_data = 16'h0987;
    dp_data    = 4'b0001;
    digit_en   = 4'b1111;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall got=%b exp=0", load_ready);
    end
    goto_pos(38);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall_late got=%b exp=0", load_ready);
    end
    step();
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_commit_a got=%b exp=1", load_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) begin
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_accept_b got=%b exp=0", load_ready);
        end
      end
      e = exp_pins(pos, 16'hABCD, 4'b1010, 4'b1111);
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start} !== e) begin
        errors++;
        $display("FAIL b2b_frame_a pos=%0d got=%h exp=%h", pos, {digit_sel, seg, seg_dp, frame_start}, e);
      end
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_commit_b got=%b exp=1", load_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      e = exp_pins(pos, 16'h0987, 4'b0001, 4'b1111);
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start} !== e) begin
        errors++;
        $display("FAIL b2b_frame_b pos=%0d got=%h exp=%h", pos, {digit_sel, seg, seg_dp, frame_start}, e);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [12:0] e;
    goto_pos(38);
    drive_load(16'h2EF5, 4'b0100, 4'b1111);
    step();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL bnd_accept got=%b exp=0", load_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      e = exp_pins(pos, 16'h0987, 4'b0001, 4'b1111);
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start} !== e) begin
        errors++;
        $display("FAIL bnd_old_frame pos=%0d got=%h exp=%h", pos, {digit_sel, seg, seg_dp, frame_start}, e);
      end
    end
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL bnd_commit got=%b exp=1", load_ready);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      e = exp_pins(pos, 16'h2EF5, 4'b0100, 4'b1111);
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start} !== e) begin
        errors++;
        $display("FAIL bnd_new_frame pos=%0d got=%h exp=%h", pos, {digit_sel, seg, seg_dp, frame_start}, e);
      end
    end
  endtask

  task automatic test_enable_mask();
    logic [12:0] e;
    drive_load(16'h8888, 4'b1111, 4'b1010);
    step();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL mask_accept got=%b exp=0", load_ready);
    end
    goto_pos(39);
    for (int i = 0; i < 40; i++) begin
      step();
      e = exp_pins(pos, 16'h8888, 4'b1111, 4'b1010);
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start} !== e) begin
        errors++;
        $display("FAIL mask_frame pos=%0d got=%h exp=%h", pos, {digit_sel, seg, seg_dp, frame_start}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    goto_pos(5);
    drive_load(16'h1111, 4'b0000, 4'b1111);
    step();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pending got=%b exp=0", load_ready);
    end
    goto_pos(15);
    checks++;
    if ({digit_sel, seg} !== {4'b0010, 7'h00}) begin
      errors++;
      $display("FAIL rstmid_drive got=%h exp=%h", {digit_sel, seg}, {4'b0010, 7'h00});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digit_sel, seg, seg_dp, frame_start, load_ready} !== {4'b0000, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async got=%h exp=%h", {digit_sel, seg, seg_dp, frame_start, load_ready},
               {4'b0000, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos   = 39;
    for (int i = 0; i < 80; i++) begin
      step();
      e = exp_pins(pos, 16'h1111, 4'b0000, 4'b0000);
      checks++;
      if ({digit_sel, seg, seg_dp, frame_start, load_ready} !== {e, 1'b1}) begin
        errors++;
        $display("FAIL rstmid_after pos=%0d got=%h exp=%h", pos,
                 {digit_sel, seg, seg_dp, frame_start, load_ready}, {e, 1'b1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_display();
    test_back_to_back();
    test_boundary_load();
    test_enable_mask();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Parametrised time-multiplexed scan controller for common-anode/cathode multi-digit 7-segment displays. Accepts a full frame of hex digit values, per-digit decimal points and per-digit enables through a valid/ready load port, and double-buffers them. It then scans the digits at a programmable per-digit rate, with an anti-ghosting blank interval, decoding each digit to segment patterns. It sits between application logic (counters, status registers) and the display pins.

## Interface
- CLK_FREQ_HZ, 27_000_000, input clock frequency
- SCAN_HZ, 1000, per-digit slot rate; DIV = CLK_FREQ_HZ/SCAN_HZ cycles per slot
- NUM_DIGITS, 4, digit count, legal 1..8
- BLANK_CYCLES, 16, cycles at slot start with all outputs off; DIV >= BLANK_CYCLES+2 (elaboration assert)
- DIG_ACTIVE_LOW, 0, digit_sel polarity
- SEG_ACTIVE_LOW, 1, seg/seg_dp polarity
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- load_valid  in  1  frame data valid
- load_ready  out  1  pending buffer empty
- digit_data  in  4*NUM_DIGITS  hex value per digit, digit i at [4i+3:4i]
- dp_data  in  NUM_DIGITS  decimal point per digit
- digit_en  in  NUM_DIGITS  1 = digit displayed, 0 = blanked
- digit_sel  out  NUM_DIGITS  one-hot digit drive (polarity per DIG_ACTIVE_LOW)
- seg  out  7  segments {g,f,e,d,c,b,a}
- seg_dp  out  1  decimal point segment
- frame_start  out  1  one-cycle pulse when digit 0 slot begins

## Operation
- Prescaler: counts 0..DIV-1, width $clog2(DIV); slot tick when count == DIV-1, then wraps to 0.
- Slot FSM: BLANK (prescaler < BLANK_CYCLES) -> DRIVE (remaining cycles) -> BLANK on tick. In BLANK, digit_sel all inactive, seg/seg_dp off.
- Digit index: increments on tick; NUM_DIGITS-1 wraps to 0 (frame boundary). NUM_DIGITS=1: index constant 0, every tick is a frame boundary.
- Buffers: pending (load side) and shadow (display side), each holding data/dp/en plus a pending_full flag.
- Handshake: load_ready = !pending_full. Transfer on load_valid && load_ready captures all inputs into pending and sets pending_full.
- Commit: at frame boundary, if pending_full, shadow <= pending and pending_full clears.
- Simultaneous load and boundary in the same cycle: commit uses pre-edge pending_full. A load accepted in that cycle commits at the next boundary.
- DRIVE: digit_sel asserts bit idx only if shadow en[idx]; seg = decode(shadow data[idx]); seg_dp = shadow dp[idx]. Masked digit: all off, slot duration unchanged.
- Decode: standard hex 0-F (0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71, active-high {g..a}); polarity applied after decode.

## Timing
- All outputs registered: pins reflect FSM/index state with 1-cycle latency.
- Reset values: digit_sel all inactive, seg/seg_dp off, load_ready=1, frame_start=0, index=0, prescaler=0, FSM=BLANK, shadow cleared (en=0), pending_full=0.
- After rst_n release: digit 0 slot starts immediately. frame_start pulses on the first output cycle of each digit-0 slot, including the first after reset.
- load_ready falls the cycle after acceptance. It rises the cycle after the commit boundary.
- Latency load -> display: new data appears in the first DRIVE cycle of the next frame after acceptance.
- Reset mid-operation clears everything asynchronously. Pending data is discarded; no partial commit.
- Frame period: NUM_DIGITS*DIV cycles exactly; no drift.

## Structure
- Shared package seven_seg_pkg: seg_pattern_t (logic [6:0]), hex_nibble_t, HEX_TO_SEG constant array (16 entries), scan_state_t enum {BLANK, DRIVE}.
- Sub-module seg_tick_gen: prescaler with tick and blank_active outputs, parametrised by DIV and BLANK_CYCLES.
- Decode is a package function; no separate module.

## Test plan
Use CLK_FREQ_HZ=1000, SCAN_HZ=100, NUM_DIGITS=4, BLANK_CYCLES=2, SEG_ACTIVE_LOW=1 unless noted.
- Reset hold then release, no load -> digit_sel=0000, seg=7F, seg_dp=1 every cycle; frame_start every 40 cycles; load_ready=1.
- Load data=0x4321, dp=0001, en=1111 -> digit 0 DRIVE shows seg=~06=79, seg_dp=0, digit_sel=0001 for 8 cycles after 2 blank cycles; digits 1..3 show 5B/4F/66 inverted.
- Two back-to-back loads with load_valid held -> second stalls (load_ready=0) until frame boundary; second frame shows second value.
- Load accepted in the exact boundary cycle -> old shadow kept for one more frame; new value appears one frame later.
- en=1010 -> slots 0 and 2 fully off for 10 cycles each; frame still 40 cycles.
- Assert rst_n low mid-DRIVE with pending_full=1 -> outputs off immediately (async); after release load_ready=1 and pending data is never displayed.
